// File: rtl/magia_tile_pkg.sv
// ---------------------------------------------------------------------------
// magia_tile_pkg
// Shared definitions for the MAGIA tile wake controller:
//   - tile_state_e : FSM state encoding (also exported on state_o for debug)
//   - N_EVT_DEF    : default number of wake event sources
//   - BOOT_DLY_DEF : default tile-enable to fetch-enable delay in cycles
//   - BOOT_CNT_W   : boot counter width (BOOT_DLY legal range is 1..255)
//   - fetchAllowed : states in which the core may fetch instructions
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package magia_tile_pkg;

  localparam int unsigned N_EVT_DEF    = 4;
  localparam int unsigned BOOT_DLY_DEF = 16;
  localparam int unsigned BOOT_CNT_W   = 8;

  // Encoding is visible to software/debug via state_o, so it is pinned.
  typedef enum logic [2:0] {
    OFF   = 3'd0,
    BOOT  = 3'd1,
    RUN   = 3'd2,
    SLEEP = 3'd3,
    WAKE  = 3'd4
  } tile_state_e;

  // The core keeps its fetch enable while sleeping so that a wake only has
  // to release the WFE stall, not restart the pipeline.
  function automatic logic fetchAllowed(input tile_state_e s);
    return (s == RUN) || (s == SLEEP) || (s == WAKE);
  endfunction

endpackage

// File: rtl/magia_tile_wake_ctrl_if.sv
// ---------------------------------------------------------------------------
// magia_tile_wake_ctrl_if
// Event bus between the event sources / CSR side and the pending tracker.
//   evt      : single-cycle event pulses, one bit per source
//   clr      : CSR write strobe clearing pending/overflow bits
//   pending  : registered pending flags
//   overflow : registered sticky lost-event flags
// Modports:
//   master : drives evt/clr, observes pending/overflow
//   slave  : the pending tracker, owns pending/overflow
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface magia_tile_wake_ctrl_if
  #(parameter int unsigned N_EVT = magia_tile_pkg::N_EVT_DEF)
  ();

  logic [N_EVT-1:0] evt;
  logic [N_EVT-1:0] clr;
  logic [N_EVT-1:0] pending;
  logic [N_EVT-1:0] overflow;

  modport master (
    output evt,
    output clr,
    input  pending,
    input  overflow
  );

  modport slave (
    input  evt,
    input  clr,
    output pending,
    output overflow
  );

endinterface

// File: rtl/magia_evt_pending.sv
// ---------------------------------------------------------------------------
// magia_evt_pending
// Per-event pending and overflow tracking for the tile wake controller.
// Ports:
//   clk_i   : tile clock
//   rst_ni  : asynchronous active-low reset
//   hold_i  : force all pending/overflow bits to 0 (tile off or turning off)
//   bus     : event bus, slave side (evt/clr in, pending/overflow out)
// Behaviour per bit k:
//   - evt sets pending; clr clears it; a simultaneous evt and clr keeps it set
//   - an evt that hits an already pending bit, with no clr, marks overflow
//   - clr clears overflow unconditionally
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module magia_evt_pending
  import magia_tile_pkg::*;
  #(parameter int unsigned N_EVT = N_EVT_DEF)
  (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   hold_i,
    magia_tile_wake_ctrl_if.slave  bus
  );

  logic [N_EVT-1:0] r_pending;
  logic [N_EVT-1:0] r_overflow;
  logic [N_EVT-1:0] w_pendingNext;
  logic [N_EVT-1:0] w_overflowNext;

  // Set wins over clear so an event arriving in the same cycle as the CSR
  // acknowledge of its predecessor is never dropped. That same collision is
  // not an overflow: the older event was consumed by the clear.
  always_comb begin
    w_pendingNext  = bus.evt | (r_pending & ~bus.clr);
    w_overflowNext = ~bus.clr & (r_overflow | (bus.evt & r_pending));
  end

  // Pending/overflow registers; held at zero while the tile is off so a
  // power-up never starts with stale wake reasons.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else if (hold_i) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= w_pendingNext;
      r_overflow <= w_overflowNext;
    end
  end

  assign bus.pending  = r_pending;
  assign bus.overflow = r_overflow;

endmodule

// File: rtl/magia_tile_wake_ctrl.sv
// ---------------------------------------------------------------------------
// magia_tile_wake_ctrl
// Tile power-up sequencing and WFE wake-up control for a MAGIA tile core.
// Parameters:
//   N_EVT    : number of wake event sources
//   BOOT_DLY : cycles from tile enable to core fetch enable (1..255)
// Ports:
//   clk_i          in  tile clock
//   rst_ni         in  asynchronous active-low reset
//   tile_enable_i  in  tile power-on/enable level
//   core_sleep_i   in  core is in WFE/WFI sleep
//   evt_i          in  single-cycle event pulses
//   evt_mask_i     in  per-event wake enable
//   evt_clr_i      in  pending/overflow clear strobes
//   fetch_enable_o out core fetch enable
//   wu_wfe_o       out wake-up level to the core
//   evt_pending_o  out pending event bits
//   evt_overflow_o out sticky lost-event flags
//   state_o        out FSM state (debug)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module magia_tile_wake_ctrl
  import magia_tile_pkg::*;
  #(
    parameter int unsigned N_EVT    = N_EVT_DEF,
    parameter int unsigned BOOT_DLY = BOOT_DLY_DEF
  )
  (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tile_enable_i,
    input  logic             core_sleep_i,
    input  logic [N_EVT-1:0] evt_i,
    input  logic [N_EVT-1:0] evt_mask_i,
    input  logic [N_EVT-1:0] evt_clr_i,
    output logic             fetch_enable_o,
    output logic             wu_wfe_o,
    output logic [N_EVT-1:0] evt_pending_o,
    output logic [N_EVT-1:0] evt_overflow_o,
    output logic [2:0]       state_o
  );

  // Last boot counter value before handing over to the core.
  localparam logic [BOOT_CNT_W-1:0] BootLast = BOOT_CNT_W'(BOOT_DLY - 1);

  tile_state_e             r_state;
  tile_state_e             w_nextState;
  logic [BOOT_CNT_W-1:0]   r_bootCnt;
  logic                    r_fetchEn;
  logic                    r_wuWfe;
  logic                    w_wakeReq;
  logic                    w_evtHold;

  magia_tile_wake_ctrl_if #(.N_EVT(N_EVT)) w_evtBus ();

  assign w_evtBus.evt = evt_i;
  assign w_evtBus.clr = evt_clr_i;

  // Events are dropped both while off and on the edge that turns the tile
  // off, so pending reads zero in the same cycle the state reads OFF.
  assign w_evtHold = (r_state == OFF) || !tile_enable_i;

  magia_evt_pending #(.N_EVT(N_EVT)) u_evt_pending (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .hold_i (w_evtHold),
    .bus    (w_evtBus)
  );

  assign evt_pending_o  = w_evtBus.pending;
  assign evt_overflow_o = w_evtBus.overflow;

  // Wake only on events that were already pending (registered), which gives
  // the evt -> pending -> wake two-cycle latency seen by the core.
  assign w_wakeReq = |(w_evtBus.pending & evt_mask_i);

  // Next-state decode. Tile disable overrides everything; in SLEEP the core
  // leaving sleep on its own takes precedence over a wake request, since
  // there is nothing left to wake.
  always_comb begin
    w_nextState = r_state;
    if (!tile_enable_i) begin
      w_nextState = OFF;
    end else begin
      case (r_state)
        OFF:     w_nextState = BOOT;
        BOOT:    if (r_bootCnt == BootLast) w_nextState = RUN;
        RUN:     if (core_sleep_i) w_nextState = SLEEP;
        SLEEP: begin
          if (!core_sleep_i)  w_nextState = RUN;
          else if (w_wakeReq) w_nextState = WAKE;
        end
        WAKE:    if (!core_sleep_i) w_nextState = RUN;
        default: w_nextState = OFF;
      endcase
    end
  end

  // State, boot counter and Moore outputs. Outputs are decoded from the next
  // state and registered alongside it, so they always match r_state while
  // staying glitch-free flop outputs. The counter restarts from 0 on every
  // entry into BOOT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= OFF;
      r_bootCnt <= '0;
      r_fetchEn <= 1'b0;
      r_wuWfe   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_fetchEn <= fetchAllowed(w_nextState);
      r_wuWfe   <= (w_nextState == WAKE);
      if ((r_state == BOOT) && (w_nextState == BOOT)) begin
        r_bootCnt <= r_bootCnt + 1'b1;
      end else begin
        r_bootCnt <= '0;
      end
    end
  end

  assign fetch_enable_o = r_fetchEn;
  assign wu_wfe_o       = r_wuWfe;
  assign state_o        = r_state;

endmodule

// File: tb/tb_magia_tile_wake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_magia_tile_wake_ctrl
// Directed self-checking bench for magia_tile_wake_ctrl (N_EVT=4,
// BOOT_DLY=16). Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_magia_tile_wake_ctrl;

  localparam int unsigned NEvt    = 4;
  localparam int unsigned BootDly = 16;

  localparam logic [31:0] StOff   = 32'd0;
  localparam logic [31:0] StBoot  = 32'd1;
  localparam logic [31:0] StRun   = 32'd2;
  localparam logic [31:0] StSleep = 32'd3;
  localparam logic [31:0] StWake  = 32'd4;

  logic            clk = 1'b0;
  logic            rstN;
  logic            tileEnable;
  logic            coreSleep;
  logic [NEvt-1:0] evtMask;
  logic            fetchEnable;
  logic            wuWfe;
  logic [2:0]      state;

  int assertCount = 0;
  int failCount   = 0;
  int cycles;

  magia_tile_wake_ctrl_if #(.N_EVT(NEvt)) evtBus ();

  magia_tile_wake_ctrl #(.N_EVT(NEvt), .BOOT_DLY(BootDly)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .tile_enable_i  (tileEnable),
    .core_sleep_i   (coreSleep),
    .evt_i          (evtBus.evt),
    .evt_mask_i     (evtMask),
    .evt_clr_i      (evtBus.clr),
    .fetch_enable_o (fetchEnable),
    .wu_wfe_o       (wuWfe),
    .evt_pending_o  (evtBus.pending),
    .evt_overflow_o (evtBus.overflow),
    .state_o        (state)
  );

  // 100 MHz tile clock
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs after a falling edge, then wait for the next
  // falling edge so the caller samples the post-edge outputs.
  task automatic applyStimulus(input logic en, input logic slp,
                               input logic [NEvt-1:0] evt,
                               input logic [NEvt-1:0] mask,
                               input logic [NEvt-1:0] clr);
    tileEnable = en;
    coreSleep  = slp;
    evtBus.evt = evt;
    evtMask    = mask;
    evtBus.clr = clr;
    @(negedge clk);
  endtask

  initial begin
    rstN       = 1'b0;
    tileEnable = 1'b0;
    coreSleep  = 1'b0;
    evtMask    = '0;
    evtBus.evt = '0;
    evtBus.clr = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_state",    32'(state),           StOff);
    checkOutput("rst_fetch",    32'(fetchEnable),     32'd0);
    checkOutput("rst_wu",       32'(wuWfe),           32'd0);
    checkOutput("rst_pending",  32'(evtBus.pending),  32'd0);
    checkOutput("rst_overflow", 32'(evtBus.overflow), 32'd0);

    // Events are ignored while the tile is off
    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    checkOutput("off_pending", 32'(evtBus.pending), 32'd0);
    checkOutput("off_state",   32'(state),          StOff);

    // Boot: fetch enable rises on the 17th edge after tile enable
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("boot_state", 32'(state),       StBoot);
    checkOutput("boot_fetch", 32'(fetchEnable), 32'd0);
    cycles = 1;
    while (!fetchEnable && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("boot_latency", 32'(cycles), 32'd17);
    checkOutput("boot_run",     32'(state),  StRun);

    // Wake: masked-in event while sleeping
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0000);
    checkOutput("wk_sleep",     32'(state),       StSleep);
    checkOutput("wk_fetch",     32'(fetchEnable), 32'd1);
    checkOutput("wk_wu0",       32'(wuWfe),       32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0000);
    checkOutput("wk_pend",      32'(evtBus.pending), 32'h2);
    checkOutput("wk_wu_t1",     32'(wuWfe),          32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0000);
    checkOutput("wk_wu_t2",     32'(wuWfe),       32'd1);
    checkOutput("wk_state",     32'(state),       StWake);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0000);
    checkOutput("wk_back_run",  32'(state),       StRun);
    checkOutput("wk_wu_off",    32'(wuWfe),       32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0010);
    checkOutput("wk_clr",       32'(evtBus.pending), 32'd0);

    // Masked-off event: pending but no wake
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("mo_sleep",     32'(state),          StSleep);
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0000);
    checkOutput("mo_pend",      32'(evtBus.pending), 32'h1);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("mo_wu",        32'(wuWfe),          32'd0);
    checkOutput("mo_state",     32'(state),          StSleep);

    // Event pending from RUN wakes on the first cycle after entering SLEEP
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    checkOutput("pr_run",       32'(state), StRun);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("pr_run_mask",  32'(state), StRun);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("pr_sleep",     32'(state), StSleep);
    checkOutput("pr_wu0",       32'(wuWfe), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("pr_wake",      32'(state), StWake);
    checkOutput("pr_wu1",       32'(wuWfe), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("pr_run2",      32'(state), StRun);

    // Wake request and core leaving sleep together: RUN wins
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("co_sleep",     32'(state), StSleep);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("co_run",       32'(state), StRun);
    checkOutput("co_wu",        32'(wuWfe), 32'd0);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b1111);
    checkOutput("co_clr_pend",  32'(evtBus.pending),  32'd0);
    checkOutput("co_clr_ovf",   32'(evtBus.overflow), 32'd0);

    // Set/clear collision and overflow on bit 2
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    checkOutput("ov_pend1",     32'(evtBus.pending),  32'h4);
    checkOutput("ov_ovf1",      32'(evtBus.overflow), 32'h0);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0100);
    checkOutput("ov_coll_pend", 32'(evtBus.pending),  32'h4);
    checkOutput("ov_coll_ovf",  32'(evtBus.overflow), 32'h0);
    applyStimulus(1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0000);
    checkOutput("ov_pend3",     32'(evtBus.pending),  32'h4);
    checkOutput("ov_ovf3",      32'(evtBus.overflow), 32'h4);
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0100);
    checkOutput("ov_clr_pend",  32'(evtBus.pending),  32'h0);
    checkOutput("ov_clr_ovf",   32'(evtBus.overflow), 32'h0);

    // Tile disable while in WAKE with every event pending
    applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0000);
    checkOutput("ds_sleep",     32'(state),          StSleep);
    checkOutput("ds_pend",      32'(evtBus.pending), 32'hF);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000);
    checkOutput("ds_wake",      32'(state),          StWake);
    applyStimulus(1'b0, 1'b1, 4'b0000, 4'b1111, 4'b0000);
    checkOutput("ds_state",     32'(state),          StOff);
    checkOutput("ds_fetch",     32'(fetchEnable),    32'd0);
    checkOutput("ds_wu",        32'(wuWfe),          32'd0);
    checkOutput("ds_pend0",     32'(evtBus.pending), 32'd0);

    // Reset mid-BOOT at counter value 7
    applyStimulus(1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000);
    repeat (7) @(negedge clk);
    checkOutput("mb_boot",      32'(state), StBoot);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mb_state",     32'(state),          StOff);
    checkOutput("mb_fetch",     32'(fetchEnable),    32'd0);
    checkOutput("mb_wu",        32'(wuWfe),          32'd0);
    checkOutput("mb_pend",      32'(evtBus.pending), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    cycles = 0;
    while (!fetchEnable && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("mb_latency",   32'(cycles), 32'(BootDly + 1));

    // Reset mid-WAKE drops fetch and wake asynchronously
    applyStimulus(1'b1, 1'b1, 4'b0001, 4'b0001, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000);
    checkOutput("mw_wake",      32'(state), StWake);
    #2 rstN = 1'b0;
    #1;
    checkOutput("mw_state",     32'(state),          StOff);
    checkOutput("mw_fetch",     32'(fetchEnable),    32'd0);
    checkOutput("mw_wu",        32'(wuWfe),          32'd0);
    checkOutput("mw_pend",      32'(evtBus.pending), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
